// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and helpers for the multi-port register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // popcount takes a fixed-width operand; callers zero-extend into it
    localparam int unsigned PC_MAX_W = 1024;
    localparam int unsigned PC_CNT_W = 11;

    function automatic logic [7:0] be_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

    function automatic logic [PC_CNT_W-1:0] popcount(input logic [PC_MAX_W-1:0] v);
        logic [PC_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PC_MAX_W; i++) begin
            cnt = cnt + PC_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wr_merge.sv
// ============================================================================
// Module      : regfile_wr_merge
// Description : Resolves all write ports for one address into merged data.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_wr_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_old,
    input  logic [NWR-1:0]             i_we,
    input  logic [NWR*ADDR_W-1:0]      i_w_addr,
    input  logic [NWR*DATA_W-1:0]      i_w_data,
    input  logic [NWR*(DATA_W/8)-1:0]  i_w_be,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_hit
);

    localparam int NB = DATA_W / 8;

    logic w_zero_blk;

    assign w_zero_blk = (ZERO_REG != 0) && (i_addr == '0);

    // Ascending port order lets the highest index win on each byte
    always_comb begin
        o_data = i_old;
        o_hit  = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (i_we[k] && (i_w_addr[k*ADDR_W +: ADDR_W] == i_addr) && !w_zero_blk) begin
                o_hit = o_hit | (|i_w_be[k*NB +: NB]);
                for (int b = 0; b < NB; b++) begin
                    o_data[b*8 +: 8] = be_merge(o_data[b*8 +: 8],
                                                i_w_data[k*DATA_W + b*8 +: 8],
                                                i_w_be[k*NB + b]);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with byte enables, bypass, scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NRD*ADDR_W-1:0]      RD_ADDR,
    output logic [NRD*DATA_W-1:0]      RD_DATA,
    output logic [NRD-1:0]             RD_BUSY,
    input  logic [NWR-1:0]             WE,
    input  logic [NWR*ADDR_W-1:0]      W_ADDR,
    input  logic [NWR*DATA_W-1:0]      W_DATA,
    input  logic [NWR*(DATA_W/8)-1:0]  W_BE,
    input  logic [NWR-1:0]             W_CLR,
    input  logic                       RSV_EN,
    input  logic [ADDR_W-1:0]          RSV_ADDR,
    output logic                       CONFLICT,
    output logic [ADDR_W:0]            BUSY_CNT
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              r_conflict;
    logic [ADDR_W:0]   r_busy_cnt;
    logic              w_conflict;

    for (genvar a = 0; a < DEPTH; a++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        logic [DATA_W-1:0] w_merged;
        logic              w_hit;

        regfile_wr_merge #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_merge (
            .i_addr   (ADDR_W'(a)),
            .i_old    (r_q),
            .i_we     (WE),
            .i_w_addr (W_ADDR),
            .i_w_data (W_DATA),
            .i_w_be   (W_BE),
            .o_data   (w_merged),
            .o_hit    (w_hit)
        );

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                r_q <= '0;
            else if (w_hit)
                r_q <= w_merged;
        end

        assign w_mem[a] = r_q;
    end

    // Clears applied first so a same-cycle reservation overrides them
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < NWR; k++) begin
            if (WE[k] && W_CLR[k])
                w_busy_nxt[W_ADDR[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (RSV_EN)
            w_busy_nxt[RSV_ADDR] = 1'b1;
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (WE[j] && WE[k]
                    && (W_ADDR[j*ADDR_W +: ADDR_W] == W_ADDR[k*ADDR_W +: ADDR_W])
                    && ((ZERO_REG == 0) || (W_ADDR[j*ADDR_W +: ADDR_W] != '0))
                    && (|(W_BE[j*NB +: NB] & W_BE[k*NB +: NB])))
                    w_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy     <= '0;
            r_conflict <= 1'b0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict;
            r_busy_cnt <= (ADDR_W+1)'(popcount(PC_MAX_W'(w_busy_nxt)));
        end
    end

    assign CONFLICT = r_conflict;
    assign BUSY_CNT = r_busy_cnt;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_zero;

        assign w_a    = RD_ADDR[i*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_a == '0);

        if (BYPASS != 0) begin : g_byp
            logic [DATA_W-1:0] w_fwd;
            logic              w_fwd_hit;
            logic              w_clr_hit;
            logic              w_rsv_hit;

            regfile_wr_merge #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NWR      (NWR),
                .ZERO_REG (ZERO_REG)
            ) u_fwd (
                .i_addr   (w_a),
                .i_old    (w_mem[w_a]),
                .i_we     (WE),
                .i_w_addr (W_ADDR),
                .i_w_data (W_DATA),
                .i_w_be   (W_BE),
                .o_data   (w_fwd),
                .o_hit    (w_fwd_hit)
            );

            always_comb begin
                w_clr_hit = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (WE[k] && W_CLR[k] && (W_ADDR[k*ADDR_W +: ADDR_W] == w_a))
                        w_clr_hit = 1'b1;
                end
            end

            assign w_rsv_hit             = RSV_EN && (RSV_ADDR == w_a);
            assign RD_DATA[i*DATA_W +: DATA_W] = w_zero ? '0 : (w_fwd_hit ? w_fwd : w_mem[w_a]);
            assign RD_BUSY[i]            = r_busy[w_a] & ~(w_clr_hit & ~w_rsv_hit);
        end else begin : g_nobyp
            assign RD_DATA[i*DATA_W +: DATA_W] = w_zero ? '0 : w_mem[w_a];
            assign RD_BUSY[i]            = r_busy[w_a];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Bench for regfile_mp, bypass and non-bypass builds side by side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic                CLK;
    logic                RST;
    logic [NRD*AW-1:0]   RD_ADDR;
    logic [NRD*DW-1:0]   RD_DATA_B, RD_DATA_N;
    logic [NRD-1:0]      RD_BUSY_B, RD_BUSY_N;
    logic [NWR-1:0]      WE;
    logic [NWR*AW-1:0]   W_ADDR;
    logic [NWR*DW-1:0]   W_DATA;
    logic [NWR*NB-1:0]   W_BE;
    logic [NWR-1:0]      W_CLR;
    logic                RSV_EN;
    logic [AW-1:0]       RSV_ADDR;
    logic                CONFLICT_B, CONFLICT_N;
    logic [AW:0]         BUSY_CNT_B, BUSY_CNT_N;

    int n_checks;
    int n_fail;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_conflict;
    int            m_cnt;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
        .CLK(CLK), .RST(RST), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA_B), .RD_BUSY(RD_BUSY_B),
        .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_BE(W_BE), .W_CLR(W_CLR),
        .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .CONFLICT(CONFLICT_B), .BUSY_CNT(BUSY_CNT_B)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
        .CLK(CLK), .RST(RST), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA_N), .RD_BUSY(RD_BUSY_N),
        .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_BE(W_BE), .W_CLR(W_CLR),
        .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .CONFLICT(CONFLICT_N), .BUSY_CNT(BUSY_CNT_N)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register contents after this cycle's writes, per-byte, later port wins
    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] base);
        logic [DW-1:0] v;
        v = base;
        if (a == '0) return base;
        for (int k = 0; k < NWR; k++)
            if (WE[k] && W_ADDR[k*AW +: AW] == a)
                for (int b = 0; b < NB; b++)
                    if (W_BE[k*NB + b]) v[b*8 +: 8] = W_DATA[k*DW + b*8 +: 8];
        return v;
    endfunction

    function automatic bit clr_pending(input logic [AW-1:0] a);
        for (int k = 0; k < NWR; k++)
            if (WE[k] && W_CLR[k] && W_ADDR[k*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
        m_conflict = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic model_check();
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            bit            eb;
            a  = RD_ADDR[i*AW +: AW];
            eb = m_busy[a] && !(clr_pending(a) && !(RSV_EN && RSV_ADDR == a));
            chk("rd_data_byp", RD_DATA_B[i*DW +: DW], (a == '0) ? '0 : fwd(a, m_mem[a]));
            chk("rd_data_nob", RD_DATA_N[i*DW +: DW], m_mem[a]);
            chk("rd_busy_byp", RD_BUSY_B[i], eb);
            chk("rd_busy_nob", RD_BUSY_N[i], m_busy[a]);
        end
        chk("conflict_byp", CONFLICT_B, m_conflict);
        chk("conflict_nob", CONFLICT_N, m_conflict);
        chk("busy_cnt_byp", BUSY_CNT_B, m_cnt);
        chk("busy_cnt_nob", BUSY_CNT_N, m_cnt);
    endtask

    task automatic model_step();
        logic [DW-1:0] nm [DEPTH];
        for (int a = 0; a < DEPTH; a++) nm[a] = fwd(AW'(a), m_mem[a]);
        m_conflict = 1'b0;
        for (int j = 0; j < NWR; j++)
            for (int k = j + 1; k < NWR; k++)
                if (WE[j] && WE[k] && W_ADDR[j*AW +: AW] == W_ADDR[k*AW +: AW]
                    && W_ADDR[j*AW +: AW] != '0 && (W_BE[j*NB +: NB] & W_BE[k*NB +: NB]) != '0)
                    m_conflict = 1'b1;
        for (int k = 0; k < NWR; k++)
            if (WE[k] && W_CLR[k]) m_busy[W_ADDR[k*AW +: AW]] = 1'b0;
        if (RSV_EN) m_busy[RSV_ADDR] = 1'b1;
        m_busy[0] = 1'b0;
        m_cnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = nm[a];
            m_cnt += int'(m_busy[a]);
        end
    endtask

    task automatic cycle();
        #1 model_check();
        @(posedge CLK);
        model_step();
    endtask

    task automatic idle();
        WE = '0; W_CLR = '0; W_BE = '0; W_ADDR = '0; W_DATA = '0;
        RSV_EN = 1'b0; RSV_ADDR = '0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        RD_ADDR[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be, input logic clr);
        WE[k] = 1'b1;
        W_ADDR[k*AW +: AW] = a;
        W_DATA[k*DW +: DW] = d;
        W_BE[k*NB +: NB]   = be;
        W_CLR[k]           = clr;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < NRD; i++) set_rd(i, rnd_addr());
        for (int k = 0; k < NWR; k++) begin
            WE[k] = ($urandom_range(0, 3) != 0);
            W_ADDR[k*AW +: AW] = rnd_addr();
            W_DATA[k*DW +: DW] = DW'($urandom);
            W_BE[k*NB +: NB]   = NB'($urandom);
            W_CLR[k]           = 1'($urandom_range(0, 1));
        end
        RSV_EN   = ($urandom_range(0, 2) == 0);
        RSV_ADDR = rnd_addr();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b0;
        RD_ADDR  = '0;
        idle();
        model_reset();

        #1 RST = 1'b1;
        set_rd(0, 5); set_rd(1, 8);
        #2;
        chk("rst_rd_data", RD_DATA_B, '0);
        chk("rst_rd_busy", RD_BUSY_B, '0);
        chk("rst_busy_cnt", BUSY_CNT_B, '0);
        chk("rst_conflict", CONFLICT_B, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Two ports colliding on r5 with overlapping low bytes
        @(negedge CLK);
        idle(); set_rd(0, 5); set_rd(1, 5);
        set_wr(0, 5, 32'h12345678, 4'hF, 1'b0);
        set_wr(1, 5, 32'hAABBCCDD, 4'h3, 1'b0);
        #1;
        chk("coll_byp_same", RD_DATA_B[31:0], 32'h1234CCDD);
        chk("coll_nob_same", RD_DATA_N[31:0], 32'h0);
        cycle();
        #1 idle();
        #1;
        chk("coll_conflict", CONFLICT_B, 1'b1);
        chk("coll_data", RD_DATA_N[31:0], 32'h1234CCDD);

        // Zero register ignores writes and reservations
        @(negedge CLK);
        idle(); set_rd(0, 0);
        set_wr(0, 0, 32'hFFFFFFFF, 4'hF, 1'b0);
        RSV_EN = 1'b1; RSV_ADDR = 5'd0;
        #1 chk("r0_byp_same", RD_DATA_B[31:0], 32'h0);
        cycle();
        #1 idle();
        #1;
        chk("r0_data", RD_DATA_N[31:0], 32'h0);
        chk("r0_busy", RD_BUSY_N[0], 1'b0);
        chk("r0_busy_cnt", BUSY_CNT_N, 6'd0);
        chk("r0_no_conflict", CONFLICT_N, 1'b0);

        // Reserve r8 while writing it, then clear with no byte enables
        @(negedge CLK);
        idle(); set_rd(0, 8);
        set_wr(0, 8, 32'hCAFEF00D, 4'hF, 1'b0);
        RSV_EN = 1'b1; RSV_ADDR = 5'd8;
        cycle();
        #1 idle();
        #1;
        chk("rsv8_busy", RD_BUSY_B[0], 1'b1);
        chk("rsv8_cnt", BUSY_CNT_B, 6'd1);
        @(negedge CLK);
        idle(); set_wr(0, 8, 32'hFFFFFFFF, 4'h0, 1'b1);
        #1;
        chk("clr8_byp_busy", RD_BUSY_B[0], 1'b0);
        chk("clr8_nob_busy", RD_BUSY_N[0], 1'b1);
        chk("clr8_byp_data", RD_DATA_B[31:0], 32'hCAFEF00D);
        cycle();
        #1 idle();
        #1;
        chk("clr8_busy", RD_BUSY_N[0], 1'b0);
        chk("clr8_data", RD_DATA_N[31:0], 32'hCAFEF00D);
        chk("clr8_cnt", BUSY_CNT_N, 6'd0);

        // Reserve and clear r9 in the same cycle: reserve wins
        @(negedge CLK);
        idle(); set_rd(0, 9);
        set_wr(1, 9, 32'h0, 4'h0, 1'b1);
        RSV_EN = 1'b1; RSV_ADDR = 5'd9;
        cycle();
        #1 idle();
        #1;
        chk("rsvclr9_busy", RD_BUSY_N[0], 1'b1);
        chk("rsvclr9_cnt", BUSY_CNT_N, 6'd1);

        // Write-to-read latency with and without bypass
        @(negedge CLK);
        idle(); set_rd(1, 3);
        set_wr(0, 3, 32'h00000042, 4'hF, 1'b0);
        #1;
        chk("r3_nob_same", RD_DATA_N[63:32], 32'h0);
        chk("r3_byp_same", RD_DATA_B[63:32], 32'h42);
        cycle();
        #1 idle();
        #1 chk("r3_nob_next", RD_DATA_N[63:32], 32'h42);

        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            rand_inputs();
            cycle();
        end

        // Reset asserted mid-cycle, held across an edge with a write present
        @(negedge CLK);
        idle(); set_rd(0, 5); set_rd(1, 3);
        #3 RST = 1'b1;
        model_reset();
        #1;
        chk("mrst_rd_byp", RD_DATA_B, '0);
        chk("mrst_rd_nob", RD_DATA_N, '0);
        chk("mrst_busy", RD_BUSY_B, '0);
        chk("mrst_cnt", BUSY_CNT_B, '0);
        chk("mrst_conflict", CONFLICT_B, 1'b0);
        set_wr(0, 5, 32'h5A5A5A5A, 4'hF, 1'b0);
        @(posedge CLK);
        #1 idle();
        #1 chk("mrst_write_lost", RD_DATA_N[31:0], 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int n = 0; n < 1000; n++) begin
            @(negedge CLK);
            rand_inputs();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
